// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit integer ALU between two valid/ready requesters.
// Round-robin arbitration, one operation in flight, result registered and held
// until the owning requester accepts it.
//
// Optional build macro: ALU_ARB_STATS_EN enables the grant/conflict counters.
// Without it the three statistics ports are tied to zero.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready          request handshake for requester N (0/1)
//   reqN_a/b/op/mod/tag       operands, ALU op, SR modifier, opaque tag
//   rspN_valid/ready          response handshake for requester N
//   rsp_res, rsp_tag          held result and tag, shared by both responses
//   grant_cnt0/1, conflict_cnt  saturating 16-bit statistics
module alu_arbiter #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req0_mod,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [2:0]       req1_op,
  input  logic             req1_mod,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp_res,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
  output logic [15:0]      conflict_cnt
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SLL  = 3'd1;
  localparam logic [2:0] OP_SLT  = 3'd2;
  localparam logic [2:0] OP_SLTU = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SR   = 3'd5;
  localparam logic [2:0] OP_OR   = 3'd6;
  localparam logic [2:0] OP_AND  = 3'd7;

  logic [0:0]        state;
  logic [0:0]        next_state;
  logic              owner_q;
  logic              last_q;
  logic [DATA_W-1:0] res_q;
  logic [TAG_W-1:0]  tag_q;

  logic              grant0;
  logic              grant1;
  logic              fire0;
  logic              fire1;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_op;
  logic              alu_mod;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] alu_res;

  // Round-robin grant: on a tie the requester that did not win last goes.
  assign grant0 = req0_valid && (!req1_valid || last_q);
  assign grant1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = (state == IDLE) && grant0 && !rst;
  assign req1_ready = (state == IDLE) && grant1 && !rst;
  assign fire0      = req0_valid && req0_ready;
  assign fire1      = req1_valid && req1_ready;

  assign rsp0_valid = (state == RESP) && !owner_q;
  assign rsp1_valid = (state == RESP) && owner_q;
  assign rsp_res    = res_q;
  assign rsp_tag    = tag_q;

  // Operand mux follows the grant so the ALU sees the winner's inputs.
  assign alu_a   = grant1 ? req1_a   : req0_a;
  assign alu_b   = grant1 ? req1_b   : req0_b;
  assign alu_op  = grant1 ? req1_op  : req0_op;
  assign alu_mod = grant1 ? req1_mod : req0_mod;
  assign shamt   = alu_b[4:0];

  // Shared ALU.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SLL:  alu_res = alu_a << shamt;
      OP_SLT:  alu_res = DATA_W'($signed(alu_a) < $signed(alu_b));
      OP_SLTU: alu_res = DATA_W'(alu_a < alu_b);
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_SR: begin
        if (alu_mod) alu_res = DATA_W'($signed(alu_a) >>> shamt);
        else         alu_res = alu_a >> shamt;
      end
      OP_OR:   alu_res = alu_a | alu_b;
      OP_AND:  alu_res = alu_a & alu_b;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic; a response drains only on the owner's ready.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (fire0 || fire1) next_state = RESP;
      RESP: if (owner_q ? rsp1_ready : rsp0_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Capture result and ownership on acceptance; held value survives the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      res_q   <= '0;
      tag_q   <= '0;
    end else if (fire0 || fire1) begin
      owner_q <= fire1;
      last_q  <= fire1;
      res_q   <= alu_res;
      tag_q   <= fire1 ? req1_tag : req0_tag;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] gcnt0_q;
  logic [CNT_W-1:0] gcnt1_q;
  logic [CNT_W-1:0] ccnt_q;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      ccnt_q  <= '0;
    end else begin
      if (fire0 && (gcnt0_q != '1)) gcnt0_q <= gcnt0_q + CNT_W'(1);
      if (fire1 && (gcnt1_q != '1)) gcnt1_q <= gcnt1_q + CNT_W'(1);
      if ((state == IDLE) && req0_valid && req1_valid && (ccnt_q != '1))
        ccnt_q <= ccnt_q + CNT_W'(1);
    end
  end

  assign grant_cnt0   = gcnt0_q;
  assign grant_cnt1   = gcnt1_q;
  assign conflict_cnt = ccnt_q;
`else
  assign grant_cnt0   = CNT_W'(0);
  assign grant_cnt1   = CNT_W'(0);
  assign conflict_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter. A reference model of the
// arbitration predicts ready/valid every cycle and pushes the expected result
// on each acceptance; the result is popped and compared when the owner drains it.
module tb_alu_arbiter;

  localparam int unsigned TAG_W = 4;
`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [2:0]       req0_op, req1_op;
  logic             req0_mod, req1_mod;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [31:0]      rsp_res;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      grant_cnt0, grant_cnt1, conflict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  exp_t sb[$];
  bit          m_state = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last  = 1'b1;
  logic [15:0] m_gc0 = '0, m_gc1 = '0, m_cc = '0;

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_mod(req0_mod), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_mod(req1_mod), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_res(rsp_res), .rsp_tag(rsp_tag),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic md);
    logic [63:0] ext;
    int sh;
    sh = int'(b[4:0]);
    case (op)
      3'd0: return a + b;
      3'd1: return a << sh;
      3'd2: return (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
      3'd3: return {31'b0, (a < b)};
      3'd4: return a ^ b;
      3'd5: begin
        ext = {{32{md & a[31]}}, a};
        ext = ext >> sh;
        return ext[31:0];
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle before the next edge.
  always @(negedge clk) begin
    logic g0, g1;
    exp_t e;
    g0 = req0_valid && (!req1_valid || m_last);
    g1 = req1_valid && (!req0_valid || !m_last);
    check("rdy_vld", {60'b0, rsp1_valid, rsp0_valid, req1_ready, req0_ready},
          {60'b0, m_state && m_owner, m_state && !m_owner,
           !rst && !m_state && g1, !rst && !m_state && g0});
    check("stats", {16'b0, grant_cnt0, grant_cnt1, conflict_cnt}, {16'b0, m_gc0, m_gc1, m_cc});
    if (m_state) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        check("rsp_res", 64'(rsp_res), 64'(sb[0].res));
        check("rsp_tag", 64'(rsp_tag), 64'(sb[0].tag));
      end
    end
    if (rst) begin
      m_state = 1'b0; m_owner = 1'b0; m_last = 1'b1;
      m_gc0 = '0; m_gc1 = '0; m_cc = '0;
      sb.delete();
    end else if (!m_state) begin
      if (STATS && req0_valid && req1_valid && m_cc != 16'hFFFF) m_cc = m_cc + 16'd1;
      if (g0 || g1) begin
        e.res = g1 ? ref_alu(req1_a, req1_b, req1_op, req1_mod)
                   : ref_alu(req0_a, req0_b, req0_op, req0_mod);
        e.tag = g1 ? req1_tag : req0_tag;
        sb.push_back(e);
        if (STATS && g0 && m_gc0 != 16'hFFFF) m_gc0 = m_gc0 + 16'd1;
        if (STATS && g1 && m_gc1 != 16'hFFFF) m_gc1 = m_gc1 + 16'd1;
        m_owner = g1; m_last = g1; m_state = 1'b1;
      end
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      if (sb.size() != 0) void'(sb.pop_front());
      m_state = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic md, input logic [TAG_W-1:0] tg);
    req0_a = a; req0_b = b; req0_op = op; req0_mod = md; req0_tag = tg;
  endtask

  task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic md, input logic [TAG_W-1:0] tg);
    req1_a = a; req1_b = b; req1_op = op; req1_mod = md; req1_tag = tg;
  endtask

  initial begin
    bit h0, h1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    set0('0, '0, 3'd0, 1'b0, '0);
    set1('0, '0, 3'd0, 1'b0, '0);

    // Reset then idle
    tick(2);
    rst = 1'b0;
    check("rst_res", 64'(rsp_res), 64'd0);
    check("rst_tag", 64'(rsp_tag), 64'd0);
    check("rst_vld", {62'b0, rsp1_valid, rsp0_valid}, 64'd0);
    check("rst_cnt", {16'b0, grant_cnt0, grant_cnt1, conflict_cnt}, 64'd0);
    tick(2);

    // Single ADD on port 0
    set0(32'd5, 32'hFFFF_FFFD, 3'd0, 1'b0, 4'd3);
    req0_valid = 1'b1;
    #1 check("add_ready", 64'(req0_ready), 64'd1);
    tick(1);
    req0_valid = 1'b0;
    check("add_res", 64'(rsp_res), 64'd2);
    check("add_tag", 64'(rsp_tag), 64'd3);
    check("add_vld", {62'b0, rsp1_valid, rsp0_valid}, 64'd1);
    rsp0_ready = 1'b1;
    tick(1);
    rsp0_ready = 1'b0;

    // Contention after a fresh reset
    rst = 1'b1; tick(1); rst = 1'b0;
    set0(32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 4'd1);
    set1(32'h8000_0000, 32'd4, 3'd5, 1'b1, 4'd2);
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick(8);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check("cont_gc0", 64'(grant_cnt0), STATS ? 64'd2 : 64'd0);
    check("cont_gc1", 64'(grant_cnt1), STATS ? 64'd2 : 64'd0);
    check("cont_cc", 64'(conflict_cnt), STATS ? 64'd4 : 64'd0);
    check("cont_last", 64'(rsp_res), 64'hF800_0000);

    // Back-pressure on port 1 while port 0 waits
    set1(32'hFF00_FF00, 32'h0F0F_0F0F, 3'd4, 1'b0, 4'd9);
    req1_valid = 1'b1;
    tick(1);
    req1_valid = 1'b0;
    set0(32'd7, 32'd8, 3'd6, 1'b0, 4'd4);
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_res", 64'(rsp_res), 64'hF00F_F00F);
      check("bp_vld", 64'(rsp1_valid), 64'd1);
      check("bp_rdy0", 64'(req0_ready), 64'd0);
      tick(1);
    end
    rsp1_ready = 1'b1;
    tick(1);
    rsp1_ready = 1'b0;
    check("bp_grant0", 64'(req0_ready), 64'd1);
    tick(1);
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    tick(1);
    rsp0_ready = 1'b0;

    // Reset while holding a result
    set1(32'hF0F0_1234, 32'h0FF0_FFFF, 3'd7, 1'b0, 4'd6);
    req1_valid = 1'b1;
    tick(1);
    req1_valid = 1'b0;
    tick(1);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("rmid_vld", {62'b0, rsp1_valid, rsp0_valid}, 64'd0);
    check("rmid_res", 64'(rsp_res), 64'd0);
    set0(32'd3, 32'd2, 3'd1, 1'b0, 4'd5);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 check("rmid_tie", {62'b0, req1_ready, req0_ready}, 64'd1);
    tick(1);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
    tick(1);
    rsp0_ready = 1'b0;

    // Valid withdrawal during RESP leaves arbitration untouched
    set0(32'h1234_5678, 32'h1111_1111, 3'd0, 1'b0, 4'd7);
    req0_valid = 1'b1;
    tick(1);
    req0_valid = 1'b0; req1_valid = 1'b1;
    tick(1);
    req1_valid = 1'b0;
    tick(1);
    rsp0_ready = 1'b1;
    tick(1);
    rsp0_ready = 1'b0;
    check("wd_idle", {62'b0, req1_ready, req0_ready}, 64'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1 check("wd_tie", {62'b0, req1_ready, req0_ready}, 64'd2);
    tick(1);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp1_ready = 1'b1;
    tick(1);
    rsp1_ready = 1'b0;

    // Random traffic honouring payload stability while waiting
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      h0 = req0_valid && !req0_ready && !rst;
      h1 = req1_valid && !req1_ready && !rst;
      @(posedge clk); #1;
      rst = ($urandom_range(63) == 0);
      if (!h0) begin
        req0_valid = 1'($urandom_range(1));
        set0($urandom, $urandom, 3'($urandom_range(7)), 1'($urandom_range(1)),
             TAG_W'($urandom_range(15)));
      end
      if (!h1) begin
        req1_valid = 1'($urandom_range(1));
        set1($urandom, $urandom, 3'($urandom_range(7)), 1'($urandom_range(1)),
             TAG_W'($urandom_range(15)));
      end
      rsp0_ready = 1'($urandom_range(1));
      rsp1_ready = 1'($urandom_range(1));
    end

    // Drain
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick(4);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit integer ALU between two requesters, e.g. the execute stage (port 0) and the address/branch-compare unit (port 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin. One operation is in flight at a time.
- The result is registered and held until the owning requester accepts it.

Parameters:
- TAG_W, 4: width of the opaque request tag, echoed unchanged with the response.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  arbiter accepts requester 0 this cycle.
- req0_a  in  32  operand a.
- req0_b  in  32  operand b.
- req0_op  in  3  ALU op: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SR, 6 OR, 7 AND.
- req0_mod  in  1  modifier; 1 with SR selects arithmetic shift.
- req0_tag  in  TAG_W  opaque tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_mod, req1_tag: same as port 0, for requester 1.
- rsp0_valid  out  1  result for requester 0 is held.
- rsp0_ready  in  1  requester 0 accepts the result.
- rsp1_valid  out  1  result for requester 1 is held.
- rsp1_ready  in  1  requester 1 accepts the result.
- rsp_res  out  32  registered result, shared by both response channels.
- rsp_tag  out  TAG_W  registered tag of the held result.
- grant_cnt0  out  16  statistics (see Optional Feature).
- grant_cnt1  out  16  statistics.
- conflict_cnt  out  16  statistics.

Behaviour:
- Two states: IDLE and RESP. Registers: state, owner_q, last_q, res_q, tag_q.

Reset (rst sampled high at an edge):
- state = IDLE, owner_q = 0, last_q = 1 (so requester 0 wins the first tie), res_q = 0, tag_q = 0.
- All counters = 0.
- While rst is high, req0_ready = req1_ready = 0.
- Reset mid-operation discards the held result. rspN_valid is 0 from the cycle after the reset edge.

IDLE:
- Grant is combinational:
  - only reqN_valid high: grant N;
  - both high: grant the index != last_q;
  - neither high: no grant.
- reqN_ready = (state == IDLE) && granted N && !rst.
- ready may depend combinationally on both valids. A requester must not make valid depend on ready.

Handshake (reqN_valid && reqN_ready at an edge):
- The ALU evaluates the granted requester's a, b, op and mod combinationally.
- res_q <= ALU result, tag_q <= reqN_tag, owner_q <= N, last_q <= N, state <= RESP.

RESP:
- rspN_valid = (state == RESP && owner_q == N). rsp_res = res_q, rsp_tag = tag_q.
- Both req*_ready are 0.
- On rsp[owner_q]_valid && rsp[owner_q]_ready: state <= IDLE. res_q and tag_q keep their value (not cleared).
- rsp ready from the non-owner is ignored.

Timing and throughput:
- Accept at edge T, response valid in cycle T+1.
- Minimum 2 cycles per operation, because acceptance and response-drain never overlap.

Other rules:
- Requester rules: payload must be stable while valid && !ready. Dropping valid before the handshake is legal and has no effect on arbiter state.
- Arithmetic: res_q is exactly the shared ALU's output for the captured inputs. SLT and SLTU yield 0 or 1, zero-extended. The arbiter does no width conversion.
- Fairness: under continuous contention, grants alternate 0,1,0,1. A requester waits at most one foreign operation.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - grant_cntN increments on each reqN handshake.
  - conflict_cnt increments each IDLE cycle, outside reset, with both req valids high.
  - All counters are 16-bit, saturate at 0xFFFF, and clear on rst.
- Undefined: counter registers are not built and the three ports are driven constant 0.

Test Plan:
- Reset, then idle: rst high 2 cycles, then low with no valids -> all ready 0 during rst; rsp*_valid 0; rsp_res 0; rsp_tag 0; counters 0.
- Single ADD, port 0: req0 a=5, b=0xFFFFFFFD, op=0, tag=3 -> req0_ready 1 that cycle; next cycle rsp0_valid=1, rsp_res=2, rsp_tag=3, rsp1_valid=0; rsp0_ready=1 returns to IDLE.
- Contention: both valid continuously, port 0 SLT a=-1, b=1; port 1 SR mod=1 a=0x80000000, b=4; rsp ready held high -> grants 0,1,0,1; results 1 and 0xF8000000 alternate; with ALU_ARB_STATS_EN, after 4 ops grant_cnt0=2, grant_cnt1=2, conflict_cnt=4.
- Back-pressure: port 1 XOR a=0xFF00FF00, b=0x0F0F0F0F with rsp1_ready low 5 cycles -> rsp1_valid and rsp_res=0xF00FF00F held stable; req0_ready 0 throughout despite req0_valid=1; req0 granted the cycle after rsp1 handshake.
- Reset mid-op: assert rst while in RESP holding a result -> next cycle rsp*_valid 0, rsp_res 0, state IDLE; first post-reset tie grants port 0.
- Valid withdrawal: req1_valid pulses 1 cycle while in RESP, then drops -> no grant to port 1, no response to port 1, last_q unchanged.
